// File: rtl/axi_burst_scheduler.sv
// Shares one burst-capable AXI master between NUM_REQ requesters: independent round-robin
// write and read channels split each whole transfer into bursts of at most MAX_BURST beats.

module axi_burst_channel #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              i_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_addr,
    input  logic [NUM_REQ*32-1:0]           i_beats,
    input  logic                            i_burst_end,
    input  logic                            i_resp_err,
    output logic [NUM_REQ-1:0]              o_grant,
    output logic [NUM_REQ-1:0]              o_done,
    output logic [NUM_REQ-1:0]              o_err,
    output logic                            o_start,
    output logic [ID_WIDTH-1:0]             o_id,
    output logic [ADDR_WIDTH-1:0]           o_addr,
    output logic [7:0]                      o_len
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE} state_t;

    state_t                  r_state;
    logic [PW-1:0]           r_ptr;
    logic [PW-1:0]           r_gidx;
    logic [31:0]             r_rem;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [8:0]              r_len;
    logic [NUM_REQ-1:0]      r_grant;
    logic [NUM_REQ-1:0]      r_done;
    logic [NUM_REQ-1:0]      r_err;
    logic                    r_start;
    logic [ID_WIDTH-1:0]     r_id;
    logic [ADDR_WIDTH-1:0]   r_out_addr;
    logic [7:0]              r_out_len;

    logic                    w_hi_found;
    logic                    w_lo_found;
    logic [PW-1:0]           w_hi_idx;
    logic [PW-1:0]           w_lo_idx;
    logic [PW-1:0]           w_pick;
    logic [PW-1:0]           w_ptr_next;
    logic [8:0]              w_len;
    logic [8:0]              w_len_m1;

    // Round robin: lowest requester at or above r_ptr wins, else lowest overall.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = PW'(j);
                if (j >= int'(r_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = PW'(j);
                end
            end
        end
    end

    assign w_pick     = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_ptr_next = (r_gidx == PW'(NUM_REQ - 1)) ? '0 : r_gidx + PW'(1);
    assign w_len      = (r_rem > 32'(MAX_BURST)) ? 9'(MAX_BURST) : r_rem[8:0];
    assign w_len_m1   = w_len - 9'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_gidx     <= '0;
            r_rem      <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_start    <= 1'b0;
            r_id       <= '0;
            r_out_addr <= '0;
            r_out_len  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; these defaults make
            // start/done single-cycle pulses unless a state overrides them below.
            r_start <= 1'b0;
            r_done  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_lo_found) begin
                        r_gidx         <= w_pick;
                        r_rem          <= i_beats[w_pick*32 +: 32];
                        r_addr         <= i_addr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
                        r_grant        <= NUM_REQ'(1) << w_pick;
                        r_err[w_pick]  <= 1'b0;
                        r_state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_rem == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_len      <= w_len;
                        r_out_len  <= w_len_m1[7:0];
                        r_out_addr <= r_addr;
                        r_id       <= ID_WIDTH'(r_gidx);
                        r_start    <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: r_state <= S_WAIT;
                S_WAIT: begin
                    if (i_resp_err) r_err[r_gidx] <= 1'b1;
                    if (i_burst_end) begin
                        r_rem   <= r_rem - 32'(r_len);
                        r_addr  <= r_addr + ADDR_WIDTH'(r_len);
                        r_state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    r_done[r_gidx] <= 1'b1;
                    r_grant        <= '0;
                    r_ptr          <= w_ptr_next;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_grant = r_grant;
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_start = r_start;
    assign o_id    = r_id;
    assign o_addr  = r_out_addr;
    assign o_len   = r_out_len;
endmodule

module axi_burst_scheduler #(
    parameter int          NUM_REQ    = 4,
    parameter int          ADDR_WIDTH = 32,
    parameter int          ID_WIDTH   = 4,
    parameter int          MAX_BURST  = 16,
    parameter logic [2:0]  BURST_SIZE = 3'd2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              wr_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   wr_addr,
    input  logic [NUM_REQ*32-1:0]           wr_beats,
    output logic [NUM_REQ-1:0]              wr_grant,
    output logic [NUM_REQ-1:0]              wr_done,
    output logic [NUM_REQ-1:0]              wr_err,
    input  logic [NUM_REQ-1:0]              rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   rd_addr,
    input  logic [NUM_REQ*32-1:0]           rd_beats,
    output logic [NUM_REQ-1:0]              rd_grant,
    output logic [NUM_REQ-1:0]              rd_done,
    output logic [NUM_REQ-1:0]              rd_err,
    output logic                            start_write,
    output logic [ID_WIDTH-1:0]             write_id,
    output logic [ADDR_WIDTH-1:0]           write_addr,
    output logic [7:0]                      write_len,
    output logic [2:0]                      write_size,
    output logic [1:0]                      write_burst,
    input  logic                            bvalid,
    input  logic                            bready,
    input  logic [1:0]                      bresp,
    output logic                            start_read,
    output logic [ID_WIDTH-1:0]             read_id,
    output logic [ADDR_WIDTH-1:0]           read_addr,
    output logic [7:0]                      read_len,
    output logic [2:0]                      read_size,
    output logic [1:0]                      read_burst,
    input  logic                            rvalid,
    input  logic                            rready,
    input  logic                            rlast,
    input  logic [1:0]                      rresp
);
    logic w_b_hs;
    logic w_r_hs;

    assign w_b_hs = bvalid & bready;
    assign w_r_hs = rvalid & rready;

    axi_burst_channel #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH), .MAX_BURST(MAX_BURST)
    ) u_wr (
        .clk(clk), .reset(reset),
        .i_req(wr_req), .i_addr(wr_addr), .i_beats(wr_beats),
        .i_burst_end(w_b_hs), .i_resp_err(w_b_hs && (bresp != 2'b00)),
        .o_grant(wr_grant), .o_done(wr_done), .o_err(wr_err),
        .o_start(start_write), .o_id(write_id), .o_addr(write_addr), .o_len(write_len)
    );

    // Read errors accumulate over every data beat; only the rlast beat ends a burst.
    axi_burst_channel #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH), .MAX_BURST(MAX_BURST)
    ) u_rd (
        .clk(clk), .reset(reset),
        .i_req(rd_req), .i_addr(rd_addr), .i_beats(rd_beats),
        .i_burst_end(w_r_hs && rlast), .i_resp_err(w_r_hs && (rresp != 2'b00)),
        .o_grant(rd_grant), .o_done(rd_done), .o_err(rd_err),
        .o_start(start_read), .o_id(read_id), .o_addr(read_addr), .o_len(read_len)
    );

    assign write_size  = BURST_SIZE;
    assign read_size   = BURST_SIZE;
    assign write_burst = 2'b01;
    assign read_burst  = 2'b01;
endmodule
